// File: rtl/control_sequencer.sv
// Instruction step sequencer: owns the step counter, gates the decoder's control word
// on memory wait-states, detects bus-timeout / step-overrun faults and runs interrupt entry.
module control_sequencer #(
    parameter int CONTROL_WIDTH = 22,
    parameter int STEP_WIDTH    = 3,
    parameter int MAX_WAIT      = 8,
    parameter int WAIT_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [STEP_WIDTH-1:0]    step,
    output logic                     inIrq,
    input  logic [CONTROL_WIDTH-1:0] decControls,
    output logic [CONTROL_WIDTH-1:0] controls,
    input  logic                     memReady,
    input  logic                     irq,
    input  logic                     irqEnable,
    output logic                     irqAck,
    output logic                     instrDone,
    output logic                     busError,
    output logic                     stepFault
);

    localparam int BIT_RESET_STATE = 21;
    localparam int BIT_IOR_D       = 19;
    localparam int BIT_MEM_WRITE   = 0;

    localparam logic [STEP_WIDTH-1:0] STEP_MAX  = '1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(MAX_WAIT - 1);

    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  in_irq_q, in_irq_d;
    logic                  bus_error_q, bus_error_d;
    logic                  step_fault_q, step_fault_d;

    logic mem_step, stall, timeout, boundary, overrun, accept;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        step_d       = step_q + STEP_WIDTH'(1);
        wait_d       = '0;
        in_irq_d     = in_irq_q;
        bus_error_d  = bus_error_q;
        step_fault_d = step_fault_q;

        // Fetch steps only count as memory steps in normal mode; entry words flag their own accesses.
        mem_step = ((step_q < STEP_WIDTH'(2)) && !in_irq_q)
                   || decControls[BIT_IOR_D] || decControls[BIT_MEM_WRITE];
        stall    = mem_step && !memReady;
        timeout  = stall && (wait_q == WAIT_LAST);
        boundary = !stall && decControls[BIT_RESET_STATE];
        overrun  = !stall && !decControls[BIT_RESET_STATE] && (step_q == STEP_MAX);
        accept   = boundary && irq && irqEnable && !in_irq_q;

        if (timeout) begin
            bus_error_d = 1'b1;
            step_d      = '0;
            in_irq_d    = 1'b0;
        end else if (stall) begin
            step_d = step_q;
            wait_d = wait_q + WAIT_WIDTH'(1);
        end else if (boundary) begin
            step_d   = '0;
            in_irq_d = accept;
        end else if (overrun) begin
            step_fault_d = 1'b1;
            step_d       = '0;
            in_irq_d     = 1'b0;
        end

        // Write enables are suppressed while waiting or aborting; selects and memWriteReq pass through.
        controls = decControls;
        if (stall || overrun) begin
            controls[7:1] = '0;
        end

        instrDone = boundary && !rst;
        irqAck    = accept && !rst;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            step_q       <= '0;
            wait_q       <= '0;
            in_irq_q     <= 1'b0;
            bus_error_q  <= 1'b0;
            step_fault_q <= 1'b0;
        end else begin
            step_q       <= step_d;
            wait_q       <= wait_d;
            in_irq_q     <= in_irq_d;
            bus_error_q  <= bus_error_d;
            step_fault_q <= step_fault_d;
        end
    end

    assign step      = step_q;
    assign inIrq     = in_irq_q;
    assign busError  = bus_error_q;
    assign stepFault = step_fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: reset, plain stepping, wait states,
// bus timeout, interrupt entry and step overrun, all with hand-computed expectations.
module tb_control_sequencer;

    localparam int CW = 22;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] step;
    logic          inIrq;
    logic [CW-1:0] decControls;
    logic [CW-1:0] controls;
    logic          memReady;
    logic          irq;
    logic          irqEnable;
    logic          irqAck;
    logic          instrDone;
    logic          busError;
    logic          stepFault;

    int n_checks = 0;
    int n_errors = 0;

    control_sequencer #(
        .CONTROL_WIDTH(CW),
        .STEP_WIDTH   (SW),
        .MAX_WAIT     (4),
        .WAIT_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .inIrq      (inIrq),
        .decControls(decControls),
        .controls   (controls),
        .memReady   (memReady),
        .irq        (irq),
        .irqEnable  (irqEnable),
        .irqAck     (irqAck),
        .instrDone  (instrDone),
        .busError   (busError),
        .stepFault  (stepFault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CW-1:0] dec, input logic ready);
        decControls = dec;
        memReady    = ready;
        #1;
    endtask

    initial begin
        // Reset cycle with inputs that would otherwise complete and accept an interrupt
        rst = 1'b1; irq = 1'b1; irqEnable = 1'b1;
        drive(22'h3FFFFF, 1'b1);
        check("rst_instrDone", 32'(instrDone), 0);
        check("rst_irqAck", 32'(irqAck), 0);
        tick();
        rst = 1'b0; irq = 1'b0; irqEnable = 1'b0;
        #1;
        check("rst_step", 32'(step), 0);
        check("rst_inIrq", 32'(inIrq), 0);
        check("rst_busError", 32'(busError), 0);
        check("rst_stepFault", 32'(stepFault), 0);
        drive(22'h3FFFFF, 1'b1);
        check("all_ones_controls", 32'(controls), 32'h3FFFFF);
        check("all_ones_instrDone", 32'(instrDone), 1);
        tick();
        check("all_ones_step", 32'(step), 0);

        // 3-step ALU op
        drive(22'h0000A0, 1'b1);
        check("alu_s0_step", 32'(step), 0);
        check("alu_s0_controls", 32'(controls), 32'h0000A0);
        check("alu_s0_instrDone", 32'(instrDone), 0);
        tick();
        drive(22'h000090, 1'b1);
        check("alu_s1_step", 32'(step), 1);
        check("alu_s1_controls", 32'(controls), 32'h000090);
        check("alu_s1_instrDone", 32'(instrDone), 0);
        tick();
        drive(22'h200008, 1'b1);
        check("alu_s2_step", 32'(step), 2);
        check("alu_s2_instrDone", 32'(instrDone), 1);
        check("alu_s2_controls", 32'(controls), 32'h200008);
        tick();
        check("alu_end_step", 32'(step), 0);

        // Two wait states on fetch step 0
        for (int i = 0; i < 2; i++) begin
            drive(22'h0030FE, 1'b0);
            check("wait_step", 32'(step), 0);
            check("wait_controls_gated", 32'(controls), 32'h003000);
            tick();
        end
        drive(22'h0030FE, 1'b1);
        check("wait_ready_step", 32'(step), 0);
        check("wait_ready_controls", 32'(controls), 32'h0030FE);
        tick();
        check("wait_after_step", 32'(step), 1);
        check("wait_busError", 32'(busError), 0);

        // Bus timeout on step 1 with MAX_WAIT=4
        for (int i = 0; i < 4; i++) begin
            drive(22'h0000FE, 1'b0);
            check("timeout_stall_step", 32'(step), 1);
            check("timeout_stall_busError", 32'(busError), 0);
            check("timeout_stall_controls", 32'(controls), 0);
            tick();
        end
        check("timeout_busError", 32'(busError), 1);
        check("timeout_step", 32'(step), 0);
        check("timeout_inIrq", 32'(inIrq), 0);
        drive(22'h000000, 1'b1);
        tick();
        drive(22'h200000, 1'b1);
        check("post_timeout_step", 32'(step), 1);
        tick();
        check("busError_sticky", 32'(busError), 1);
        check("post_timeout_wrap", 32'(step), 0);

        // Interrupt raised mid-instruction, accepted only at the step-6 boundary
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                irq = 1'b1; irqEnable = 1'b1;
            end
            drive(22'h000080, 1'b1);
            check("ret_step", 32'(step), i);
            check("ret_irqAck", 32'(irqAck), 0);
            check("ret_instrDone", 32'(instrDone), 0);
            tick();
        end
        drive(22'h200000, 1'b1);
        check("ret_s6_step", 32'(step), 6);
        check("ret_s6_irqAck", 32'(irqAck), 1);
        check("ret_s6_instrDone", 32'(instrDone), 1);
        tick();
        check("entry_inIrq", 32'(inIrq), 1);
        check("entry_step", 32'(step), 0);

        // Entry step 0 is not a memory step, so memReady=0 must not stall it
        drive(22'h000040, 1'b0);
        check("entry_s0_controls", 32'(controls), 32'h000040);
        check("entry_s0_irqAck", 32'(irqAck), 0);
        tick();
        irq = 1'b0;
        drive(22'h000001, 1'b1);
        check("entry_s1_step", 32'(step), 1);
        check("entry_s1_inIrq", 32'(inIrq), 1);
        tick();
        drive(22'h000080, 1'b1);
        check("entry_s2_step", 32'(step), 2);
        tick();
        irq = 1'b1;
        drive(22'h200080, 1'b1);
        check("entry_s3_step", 32'(step), 3);
        check("entry_s3_irqAck", 32'(irqAck), 0);
        check("entry_s3_instrDone", 32'(instrDone), 1);
        check("entry_s3_controls", 32'(controls), 32'h200080);
        tick();
        check("entry_end_inIrq", 32'(inIrq), 0);
        check("entry_end_step", 32'(step), 0);

        // irq held with irqEnable low is never accepted
        irqEnable = 1'b0;
        drive(22'h000000, 1'b1);
        tick();
        drive(22'h200000, 1'b1);
        check("masked_instrDone", 32'(instrDone), 1);
        check("masked_irqAck", 32'(irqAck), 0);
        tick();
        check("masked_inIrq", 32'(inIrq), 0);
        irq = 1'b0;

        // Step overrun: resetState never asserted
        check("pre_overrun_stepFault", 32'(stepFault), 0);
        for (int i = 0; i < 7; i++) begin
            drive(22'h0000FE, 1'b1);
            check("overrun_step", 32'(step), i);
            check("overrun_controls", 32'(controls), 32'h0000FE);
            tick();
        end
        drive(22'h0000FE, 1'b1);
        check("overrun_s7_step", 32'(step), 7);
        check("overrun_s7_controls", 32'(controls), 0);
        check("overrun_s7_instrDone", 32'(instrDone), 0);
        check("overrun_s7_stepFault", 32'(stepFault), 0);
        tick();
        check("overrun_stepFault", 32'(stepFault), 1);
        check("overrun_wrap_step", 32'(step), 0);
        check("overrun_wrap_inIrq", 32'(inIrq), 0);

        // Reset clears the sticky fault flags
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("final_busError", 32'(busError), 0);
        check("final_stepFault", 32'(stepFault), 0);
        check("final_step", 32'(step), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
